// File: rtl/urna_pkg.sv
// Shared types and helpers for the ballot counter: phase enum, null code and vote-code decoding.
package urna_pkg;

  typedef enum logic [1:0] {
    IDLE,
    VOTING,
    CLOSED
  } estado_t;

  localparam int CODE_NULL = 0;

  // Codes 1..n map to candidates 0..n-1 (mirrored when swap is set); anything else is null (index n).
  function automatic int cand_index(input int code, input logic swap, input int n);
    int k;
    if (code == CODE_NULL || code > n) begin
      return n;
    end
    k = code - 1;
    return swap ? (n - 1 - k) : k;
  endfunction

  // Decimal digits needed for a w-bit unsigned value: ceil(w * log10(2)).
  function automatic int bcd_digits(input int w);
    return (w * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Double-dabble binary to BCD converter; combinational shift-add-3 network with one output register.
module bin2bcd_seq #(
  parameter int IN_W = 8,
  parameter int DIG  = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [IN_W-1:0]      i_bin,
  output logic [4*DIG-1:0]     o_bcd
);

  logic [4*DIG-1:0] w_bcd;
  logic [IN_W-1:0]  w_bin;
  logic [4*DIG-1:0] r_bcd;

  always_comb begin
    w_bcd = '0;
    w_bin = i_bin;
    for (int i = 0; i < IN_W; i++) begin
      for (int d = 0; d < DIG; d++) begin
        if (w_bcd[4*d +: 4] >= 4'd5) begin
          w_bcd[4*d +: 4] = w_bcd[4*d +: 4] + 4'd3;
        end
      end
      {w_bcd, w_bin} = {w_bcd[4*DIG-2:0], w_bin, 1'b0};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_bcd <= '0;
    end else begin
      r_bcd <= w_bcd;
    end
  end

  assign o_bcd = r_bcd;

endmodule

// File: rtl/urna_n_candidatos.sv
// Ballot counter for N_CAND candidates plus null, with IDLE/VOTING/CLOSED phases; totals publish on close.
// Optional registered BCD view of the selected total when URNA_BCD_EN is defined.
module urna_n_candidatos
  import urna_pkg::*;
#(
  parameter int N_CAND = 2,
  parameter int CNT_W  = 8,
  parameter int CODE_W = 4,
  parameter int SEL_W  = $clog2(N_CAND + 1)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [CODE_W-1:0]       voto,
  input  logic                    swap,
  input  logic                    valid,
  input  logic                    finish,
  input  logic [SEL_W-1:0]        res_sel,
  output logic [N_CAND*CNT_W-1:0] tot,
  output logic [CNT_W-1:0]        tnull,
  output logic [CNT_W-1:0]        res_total,
  output logic                    aberta,
  output logic                    fechada,
  output logic                    sat
`ifdef URNA_BCD_EN
  ,
  output logic [4*bcd_digits(CNT_W)-1:0] res_bcd
`endif
);

  localparam int               NB       = N_CAND + 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [SEL_W-1:0] SEL_NULL = SEL_W'(N_CAND);

  if (N_CAND < 2 || N_CAND > 14 || (2 ** CODE_W) <= N_CAND) begin : g_param_err
    $error("urna_n_candidatos: illegal N_CAND/CODE_W combination");
  end

  estado_t          r_state;
  estado_t          w_state_nxt;
  logic             r_valid_q;
  logic             r_finish_q;
  logic             w_v_rise;
  logic             w_f_rise;
  logic [CNT_W-1:0] r_cnt     [NB];
  logic [CNT_W-1:0] w_cnt_nxt [NB];
  logic [CNT_W-1:0] r_pub     [NB];
  logic             r_sat;
  logic             w_sat_hit;
  int               w_idx;

  assign w_v_rise = valid & ~r_valid_q;
  assign w_f_rise = finish & ~r_finish_q;

  // Edge-detect history resets high so levels held across reset never look like a new edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid_q  <= 1'b1;
      r_finish_q <= 1'b1;
      r_state    <= IDLE;
    end else begin
      r_valid_q  <= valid;
      r_finish_q <= finish;
      r_state    <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    aberta      = 1'b0;
    fechada     = 1'b0;
    case (r_state)
      IDLE: begin
        w_state_nxt = VOTING;
      end
      VOTING: begin
        aberta = 1'b1;
        if (w_f_rise) begin
          w_state_nxt = CLOSED;
        end
      end
      CLOSED: begin
        fechada = 1'b1;
        if (w_f_rise) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Next counter values; also what gets published, so a vote coinciding with the close is included.
  always_comb begin
    w_idx     = cand_index(int'(voto), swap, N_CAND);
    w_sat_hit = 1'b0;
    for (int i = 0; i < NB; i++) begin
      w_cnt_nxt[i] = r_cnt[i];
      if (r_state == VOTING && w_v_rise && i == w_idx) begin
        if (r_cnt[i] != CNT_MAX) begin
          w_cnt_nxt[i] = r_cnt[i] + 1'b1;
        end
        if (w_cnt_nxt[i] == CNT_MAX) begin
          w_sat_hit = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NB; i++) begin
        r_cnt[i] <= '0;
        r_pub[i] <= '0;
      end
      r_sat <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          for (int i = 0; i < NB; i++) begin
            r_cnt[i] <= '0;
          end
          r_sat <= 1'b0;
        end
        VOTING: begin
          for (int i = 0; i < NB; i++) begin
            r_cnt[i] <= w_cnt_nxt[i];
          end
          if (w_sat_hit) begin
            r_sat <= 1'b1;
          end
          if (w_f_rise) begin
            for (int i = 0; i < NB; i++) begin
              r_pub[i] <= w_cnt_nxt[i];
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  for (genvar k = 0; k < N_CAND; k++) begin : g_tot
    assign tot[k*CNT_W +: CNT_W] = r_pub[k];
  end

  assign tnull = r_pub[N_CAND];
  assign sat   = r_sat;

  always_comb begin
    res_total = '0;
    if (res_sel <= SEL_NULL) begin
      res_total = r_pub[res_sel];
    end
  end

`ifdef URNA_BCD_EN
  bin2bcd_seq #(
    .IN_W (CNT_W),
    .DIG  (bcd_digits(CNT_W))
  ) u_bcd (
    .clock (clock),
    .reset (reset),
    .i_bin (res_total),
    .o_bcd (res_bcd)
  );
`endif

endmodule
